// File: rtl/frame_cmd_parser.sv
// UART command-frame parser for the matrix-vector engine: validates
// INIT/LEN/CMD/payload/STOP frames and streams payload into the matrix FIFO and vector file.
module frame_cmd_parser #(
    parameter int                     WORD_LENGTH    = 8,
    parameter int                     MAX_DIM        = 8,
    parameter logic [WORD_LENGTH-1:0] INIT_BYTE      = 8'hFE,
    parameter logic [WORD_LENGTH-1:0] STOP_BYTE      = 8'hEF,
    parameter int                     TIMEOUT_CYCLES = 100000,
    localparam int                    IW             = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_ready,
    input  logic [WORD_LENGTH-1:0] data_in,
    output logic                   push_matrix,
    output logic                   push_vector,
    output logic [IW-1:0]          vector_index,
    output logic [WORD_LENGTH-1:0] data_out,
    output logic [WORD_LENGTH-1:0] matrix_size,
    output logic                   start_compute,
    output logic                   resend,
    output logic                   clear_buffers,
    output logic                   frame_done,
    output logic                   error,
    output logic [2:0]             error_code,
    output logic                   busy
);
    localparam int W  = WORD_LENGTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [W-1:0] OP_SET_SIZE     = W'(1);
    localparam logic [W-1:0] OP_RESEND       = W'(2);
    localparam logic [W-1:0] OP_INIT_CAPTURE = W'(3);
    localparam logic [W-1:0] OP_DATA_CAPTURE = W'(4);
    localparam logic [W-1:0] MAX_DIM_W       = W'(MAX_DIM);

    localparam logic [2:0] E_LEN_ZERO  = 3'd1;
    localparam logic [2:0] E_OPCODE    = 3'd2;
    localparam logic [2:0] E_LENGTH    = 3'd3;
    localparam logic [2:0] E_NOT_READY = 3'd4;
    localparam logic [2:0] E_SIZE      = 3'd5;
    localparam logic [2:0] E_STOP      = 3'd6;
    localparam logic [2:0] E_TIMEOUT   = 3'd7;

    // Timer value one short of the limit: the idle edge that would make it
    // reach TIMEOUT_CYCLES-1 is the one that aborts the frame.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_CMD, S_PAYLOAD, S_STOP_CHK, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE, PH_MATRIX, PH_VECTOR
    } phase_t;

    state_t         state;
    phase_t         phase;
    logic [W-1:0]   len;
    logic [W-1:0]   cmd;
    logic [W-1:0]   byte_cnt;
    logic [W-1:0]   pend_size;
    logic [TW-1:0]  timer;
    logic [IW-1:0]  vec_cnt;
    logic           cap_vec;

    logic [2*W-1:0] dim_sq;
    logic [2*W-1:0] len_wide;
    logic [2*W-1:0] mat_len;
    logic [2*W-1:0] vec_len;
    logic           in_frame;
    logic           timed_out;
    logic           err_now;
    logic [2:0]     err_code_now;

    assign dim_sq   = {{W{1'b0}}, matrix_size} * {{W{1'b0}}, matrix_size};
    assign len_wide = {{W{1'b0}}, len};
    assign mat_len  = dim_sq + (2*W)'(1);
    assign vec_len  = {{W{1'b0}}, matrix_size} + (2*W)'(1);

    assign in_frame  = (state == S_LEN) || (state == S_CMD) ||
                       (state == S_PAYLOAD) || (state == S_STOP_CHK);
    assign timed_out = in_frame && !data_ready && (timer == TIMER_LAST);

    // Frame rejection decision; the sequential block only acts on it.
    always_comb begin
        err_now      = 1'b0;
        err_code_now = 3'd0;
        case (state)
            S_LEN: begin
                if (data_ready && data_in == '0) begin
                    err_now      = 1'b1;
                    err_code_now = E_LEN_ZERO;
                end
            end
            S_CMD: begin
                if (data_ready) begin
                    case (data_in)
                        OP_SET_SIZE: begin
                            if (len != W'(2)) begin
                                err_now      = 1'b1;
                                err_code_now = E_LENGTH;
                            end
                        end
                        OP_RESEND, OP_INIT_CAPTURE: begin
                            if (len != W'(1)) begin
                                err_now      = 1'b1;
                                err_code_now = E_LENGTH;
                            end
                        end
                        OP_DATA_CAPTURE: begin
                            if (phase == PH_NONE || matrix_size == '0) begin
                                err_now      = 1'b1;
                                err_code_now = E_NOT_READY;
                            end else if ((phase == PH_MATRIX && len_wide != mat_len) ||
                                         (phase == PH_VECTOR && len_wide != vec_len)) begin
                                err_now      = 1'b1;
                                err_code_now = E_LENGTH;
                            end
                        end
                        default: begin
                            err_now      = 1'b1;
                            err_code_now = E_OPCODE;
                        end
                    endcase
                end
            end
            S_PAYLOAD: begin
                if (data_ready && cmd == OP_SET_SIZE &&
                    (data_in == '0 || data_in > MAX_DIM_W)) begin
                    err_now      = 1'b1;
                    err_code_now = E_SIZE;
                end
            end
            S_STOP_CHK: begin
                if (data_ready && data_in != STOP_BYTE) begin
                    err_now      = 1'b1;
                    err_code_now = E_STOP;
                end
            end
            default: ;
        endcase
        if (timed_out) begin
            err_now      = 1'b1;
            err_code_now = E_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            phase         <= PH_NONE;
            len           <= '0;
            cmd           <= '0;
            byte_cnt      <= '0;
            pend_size     <= '0;
            timer         <= '0;
            vec_cnt       <= '0;
            cap_vec       <= 1'b0;
            push_matrix   <= 1'b0;
            push_vector   <= 1'b0;
            vector_index  <= '0;
            data_out      <= '0;
            matrix_size   <= '0;
            start_compute <= 1'b0;
            resend        <= 1'b0;
            clear_buffers <= 1'b0;
            frame_done    <= 1'b0;
            error         <= 1'b0;
            error_code    <= '0;
            busy          <= 1'b0;
        end else begin
            push_matrix   <= 1'b0;
            push_vector   <= 1'b0;
            start_compute <= 1'b0;
            resend        <= 1'b0;
            clear_buffers <= 1'b0;
            frame_done    <= 1'b0;
            error         <= 1'b0;

            if (in_frame)
                timer <= data_ready ? '0 : timer + TW'(1);

            if (err_now) begin
                state         <= S_ERR;
                error         <= 1'b1;
                clear_buffers <= 1'b1;
                error_code    <= err_code_now;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (data_ready && data_in == INIT_BYTE) begin
                            state <= S_LEN;
                            busy  <= 1'b1;
                            timer <= '0;
                        end
                    end
                    S_LEN: begin
                        if (data_ready) begin
                            len   <= data_in;
                            state <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (data_ready) begin
                            cmd      <= data_in;
                            byte_cnt <= len - W'(1);
                            vec_cnt  <= '0;
                            cap_vec  <= (phase == PH_VECTOR);
                            if (data_in == OP_INIT_CAPTURE)
                                phase <= PH_MATRIX;
                            state <= (data_in == OP_SET_SIZE || data_in == OP_DATA_CAPTURE)
                                     ? S_PAYLOAD : S_STOP_CHK;
                        end
                    end
                    S_PAYLOAD: begin
                        if (data_ready) begin
                            byte_cnt <= byte_cnt - W'(1);
                            if (byte_cnt == W'(1))
                                state <= S_STOP_CHK;
                            if (cmd == OP_SET_SIZE) begin
                                pend_size <= data_in;
                            end else if (cap_vec) begin
                                push_vector  <= 1'b1;
                                data_out     <= data_in;
                                vector_index <= vec_cnt;
                                vec_cnt      <= vec_cnt + IW'(1);
                            end else begin
                                push_matrix <= 1'b1;
                                data_out    <= data_in;
                            end
                        end
                    end
                    S_STOP_CHK: begin
                        if (data_ready) begin
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // Frame side effects land one cycle after frame_done.
                        case (cmd)
                            OP_SET_SIZE: begin
                                matrix_size <= pend_size;
                                phase       <= PH_NONE;
                            end
                            OP_RESEND: resend <= 1'b1;
                            OP_DATA_CAPTURE: begin
                                if (cap_vec) begin
                                    start_compute <= 1'b1;
                                    phase         <= PH_NONE;
                                end else begin
                                    phase <= PH_VECTOR;
                                end
                            end
                            default: ;
                        endcase
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    S_ERR: begin
                        phase <= PH_NONE;
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_cmd_parser.sv
// Directed bench for frame_cmd_parser: frame sequences with hand-computed
// expectations, pulse counts taken by a negedge monitor.
module tb_frame_cmd_parser;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_ready = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       push_matrix, push_vector;
    logic [2:0] vector_index;
    logic [7:0] data_out, matrix_size;
    logic       start_compute, resend, clear_buffers, frame_done, error, busy;
    logic [2:0] error_code;

    frame_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .data_ready(data_ready), .data_in(data_in),
        .push_matrix(push_matrix), .push_vector(push_vector),
        .vector_index(vector_index), .data_out(data_out),
        .matrix_size(matrix_size), .start_compute(start_compute),
        .resend(resend), .clear_buffers(clear_buffers),
        .frame_done(frame_done), .error(error), .error_code(error_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int cyc = 0;
    int n_mat = 0, n_vec = 0, n_fd = 0, n_sc = 0, n_rs = 0, n_err = 0, n_clr = 0;
    int fd_cyc = 0, sc_cyc = 0;
    logic [7:0] mat_data [0:31];
    logic [7:0] vec_data [0:31];
    logic [2:0] vec_idx  [0:31];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (push_matrix) begin
            if (n_mat < 32) mat_data[n_mat] <= data_out;
            n_mat <= n_mat + 1;
        end
        if (push_vector) begin
            if (n_vec < 32) begin
                vec_data[n_vec] <= data_out;
                vec_idx[n_vec]  <= vector_index;
            end
            n_vec <= n_vec + 1;
        end
        if (frame_done) begin
            n_fd   <= n_fd + 1;
            fd_cyc <= cyc;
        end
        if (start_compute) begin
            n_sc   <= n_sc + 1;
            sc_cyc <= cyc;
        end
        if (resend)        n_rs  <= n_rs + 1;
        if (error)         n_err <= n_err + 1;
        if (clear_buffers) n_clr <= n_clr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data_ready = 1'b1;
        data_in    = b;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_size(input logic [7:0] n);
        send_byte(8'hFE); send_byte(8'h02); send_byte(8'h01); send_byte(n); send_byte(8'hEF);
        idle(3);
    endtask

    task automatic init_capture();
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h03); send_byte(8'hEF);
        idle(3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_fd, b_err, b_mat, b_clr, b_rs;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {push_matrix, push_vector, vector_index, data_out, matrix_size,
                           start_compute, resend, clear_buffers, frame_done, error,
                           error_code, busy}, 32'h0);
        reset = 1'b0;
        idle(2);

        // SET_SIZE n=3
        set_size(8'h03);
        chk("size_set", matrix_size, 8'h03);
        chk("size_fd", n_fd, 1);
        chk("size_noerr", n_err, 0);
        chk("size_busy", busy, 0);

        // matrix then vector capture
        init_capture();
        b_fd = n_fd;
        send_byte(8'hFE); send_byte(8'h0A); send_byte(8'h04);
        for (int i = 0; i < 9; i++) send_byte(8'h11 + 8'(i));
        send_byte(8'hEF);
        idle(3);
        chk("mat_cnt", n_mat, 9);
        for (int i = 0; i < 9; i++) chk("mat_data", mat_data[i], 8'h11 + 8'(i));
        chk("mat_fd", n_fd - b_fd, 1);
        send_byte(8'hFE); send_byte(8'h04); send_byte(8'h04);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        send_byte(8'hEF);
        idle(3);
        chk("vec_cnt", n_vec, 3);
        for (int i = 0; i < 3; i++) begin
            chk("vec_idx", vec_idx[i], 3'(i));
            chk("vec_data", vec_data[i], 8'hA1 + 8'(i));
        end
        chk("sc_cnt", n_sc, 1);
        chk("sc_delay", sc_cyc - fd_cyc, 1);
        chk("vec_noerr", n_err, 0);

        // matrix length mismatch
        init_capture();
        b_mat = n_mat; b_err = n_err; b_clr = n_clr;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h04);
        idle(3);
        chk("len_err", n_err - b_err, 1);
        chk("len_code", error_code, 3);
        chk("len_clr", n_clr - b_clr, 1);
        chk("len_nopush", n_mat - b_mat, 0);

        // bad STOP on RESEND, then a good RESEND
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h02); send_byte(8'hEE);
        idle(3);
        chk("stop_code", error_code, 6);
        chk("stop_noresend", n_rs, 0);
        b_rs = n_rs;
        send_byte(8'hFE); send_byte(8'h01); send_byte(8'h02); send_byte(8'hEF);
        idle(3);
        chk("resend_cnt", n_rs - b_rs, 1);

        // inter-byte timeout
        b_err = n_err;
        send_byte(8'hFE);
        @(negedge clk);
        data_ready = 1'b1;
        data_in    = 8'h02;
        @(posedge clk);
        @(negedge clk);
        data_ready = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("to_early", error, 0);
        @(posedge clk);
        #1;
        chk("to_err", error, 1);
        chk("to_code", error_code, 7);
        idle(4);
        chk("to_busy", busy, 0);
        set_size(8'h05);
        chk("to_recover", matrix_size, 8'h05);
        chk("to_onlyone", n_err - b_err, 1);

        // reset mid-payload
        init_capture();
        send_byte(8'hFE); send_byte(8'h1A); send_byte(8'h04);
        send_byte(8'h21); send_byte(8'h22);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_outs", {push_matrix, push_vector, vector_index, data_out, matrix_size,
                         start_compute, resend, clear_buffers, frame_done, error,
                         error_code, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        send_byte(8'hFE); send_byte(8'h0A); send_byte(8'h04);
        idle(3);
        chk("rst_code", error_code, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
